// File: rtl/bus_arbiter_mux.sv
// N-master shared-bus arbiter and address/data steering mux.
// Active-low requests and grants. The bus is held for at most MAX_HOLD
// cycles when another master is waiting. Every change of owner passes
// through a one-cycle HANDOFF state, so two grants never abut.
module bus_arbiter_mux #(
   parameter int NMASTERS   = 4,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_HOLD   = 16,
   localparam int OW        = $clog2(NMASTERS),
   localparam int HW        = $clog2(MAX_HOLD + 1)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NMASTERS-1:0]            breq_,
   output logic [NMASTERS-1:0]            bgrt_,
   input  logic [NMASTERS*ADDR_WIDTH-1:0] m_addr,
   input  logic [NMASTERS*DATA_WIDTH-1:0] m_wdata,
   input  logic [NMASTERS-1:0]            m_rw_,
   output logic [DATA_WIDTH-1:0]          m_rdata,
   output logic [ADDR_WIDTH-1:0]          s_addr,
   output logic [DATA_WIDTH-1:0]          s_wdata,
   output logic                           s_rw_,
   input  logic [DATA_WIDTH-1:0]          s_rdata,
   input  logic                           prio_mode,
   output logic [OW-1:0]                  owner,
   output logic                           bus_busy
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] GRANT   = 2'd1;
   localparam logic [1:0] HANDOFF = 2'd2;

   logic [1:0]          state;
   logic [OW-1:0]       rr_ptr;
   logic [HW-1:0]       hold;
   logic [NMASTERS-1:0] req;
   logic [NMASTERS-1:0] others;
   logic [OW-1:0]       win;
   logic [OW-1:0]       win_next;
   logic                any_req;
   logic                hold_max;
   logic [OW-1:0]       base;
   int                  idx;

   // Winner search: first requester at or after the base index, wrapping.
   // Fixed priority is just a search that always starts at master 0.
   always_comb begin
      req     = ~breq_;
      win     = '0;
      any_req = 1'b0;
      idx     = 0;
      base    = prio_mode ? rr_ptr : '0;
      for (int i = 0; i < NMASTERS; i++) begin
         idx = (int'(base) + i) % NMASTERS;
         if (!any_req && req[idx]) begin
            any_req = 1'b1;
            win     = OW'(idx);
         end
      end
      win_next = (win == OW'(NMASTERS - 1)) ? '0 : win + OW'(1);
   end

   // Requests from anyone other than the current owner, used for preemption.
   always_comb begin
      others        = req;
      others[owner] = 1'b0;
      hold_max      = (hold == HW'(MAX_HOLD));
   end

   // Arbitration FSM: grant, hold count with saturation, forced dead cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         bgrt_    <= '1;
         owner    <= '0;
         bus_busy <= 1'b0;
         rr_ptr   <= '0;
         hold     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  bgrt_      <= '1;
                  bgrt_[win] <= 1'b0;
                  owner      <= win;
                  bus_busy   <= 1'b1;
                  hold       <= HW'(1);
                  rr_ptr     <= win_next;
                  state      <= GRANT;
               end
            end
            GRANT: begin
               // Voluntary release, or preemption once the hold budget is spent
               if (breq_[owner] || (hold_max && |others)) begin
                  bgrt_    <= '1;
                  bus_busy <= 1'b0;
                  state    <= HANDOFF;
               end else if (!hold_max) begin
                  hold <= hold + HW'(1);
               end
            end
            HANDOFF: state <= IDLE;
            default: begin
               state    <= IDLE;
               bgrt_    <= '1;
               bus_busy <= 1'b0;
            end
         endcase
      end
   end

   // Slave-side mux: only the granted owner can ever reach the slave;
   // an idle bus presents a harmless read of address 0.
   always_comb begin
      m_rdata = s_rdata;
      if (bus_busy) begin
         s_addr  = m_addr[int'(owner)*ADDR_WIDTH +: ADDR_WIDTH];
         s_wdata = m_wdata[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
         s_rw_   = m_rw_[owner];
      end else begin
         s_addr  = '0;
         s_wdata = '0;
         s_rw_   = 1'b1;
      end
   end

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Directed bench for bus_arbiter_mux (4 masters, MAX_HOLD 16).
module tb_bus_arbiter_mux;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  breq_;
   logic [3:0]  bgrt_;
   logic [63:0] m_addr;
   logic [127:0] m_wdata;
   logic [3:0]  m_rw_;
   logic [31:0] m_rdata;
   logic [15:0] s_addr;
   logic [31:0] s_wdata;
   logic        s_rw_;
   logic [31:0] s_rdata;
   logic        prio_mode;
   logic [1:0]  owner;
   logic        bus_busy;

   int cmp = 0;
   int err = 0;

   bus_arbiter_mux #(.NMASTERS(4), .ADDR_WIDTH(16), .DATA_WIDTH(32), .MAX_HOLD(16)) dut (
      .clk(clk), .reset(reset), .breq_(breq_), .bgrt_(bgrt_),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_rw_(m_rw_), .m_rdata(m_rdata),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_rw_(s_rw_), .s_rdata(s_rdata),
      .prio_mode(prio_mode), .owner(owner), .bus_busy(bus_busy)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle; inputs are driven here as well.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_wait();
      breq_ = 4'b1111;
      step(); step(); step();
   endtask

   task automatic test_reset_state();
      cmp++; if (bgrt_ !== 4'b1111) begin err++; $display("FAIL rst_bgrt got %b exp 1111", bgrt_); end
      cmp++; if (bus_busy !== 1'b0) begin err++; $display("FAIL rst_busy got %b exp 0", bus_busy); end
      cmp++; if (owner !== 2'd0) begin err++; $display("FAIL rst_owner got %0d exp 0", owner); end
      cmp++; if (s_rw_ !== 1'b1 || s_addr !== 16'h0 || s_wdata !== 32'h0) begin err++; $display("FAIL rst_mux got rw=%b a=%h d=%h exp 1/0/0", s_rw_, s_addr, s_wdata); end
   endtask

   task automatic test_single();
      breq_ = 4'b1101;
      step();
      cmp++; if (bgrt_ !== 4'b1101) begin err++; $display("FAIL single_bgrt got %b exp 1101", bgrt_); end
      cmp++; if (owner !== 2'd1 || bus_busy !== 1'b1) begin err++; $display("FAIL single_owner got %0d busy %b exp 1/1", owner, bus_busy); end
      cmp++; if (s_addr !== 16'hA1A1) begin err++; $display("FAIL single_addr got %h exp a1a1", s_addr); end
      cmp++; if (s_wdata !== 32'hD1D1_0001 || s_rw_ !== 1'b0) begin err++; $display("FAIL single_wr got %h rw=%b exp d1d10001/0", s_wdata, s_rw_); end
      cmp++; if (m_rdata !== 32'hDEAD_BEEF) begin err++; $display("FAIL single_rdata got %h exp deadbeef", m_rdata); end
      breq_ = 4'b1111;
      step();
      cmp++; if (bgrt_ !== 4'b1111 || bus_busy !== 1'b0) begin err++; $display("FAIL single_release got %b busy %b exp 1111/0", bgrt_, bus_busy); end
      idle_wait();
   endtask

   task automatic test_reset();
      breq_ = 4'b1101;
      step();
      cmp++; if (bgrt_ !== 4'b1101 || s_rw_ !== 1'b0) begin err++; $display("FAIL rstmid_pre got %b rw=%b exp 1101/0", bgrt_, s_rw_); end
      #2 reset = 1'b1;
      #1;
      cmp++; if (bgrt_ !== 4'b1111) begin err++; $display("FAIL rstmid_bgrt got %b exp 1111", bgrt_); end
      cmp++; if (s_rw_ !== 1'b1 || bus_busy !== 1'b0) begin err++; $display("FAIL rstmid_rw got rw=%b busy=%b exp 1/0", s_rw_, bus_busy); end
      breq_ = 4'b1111;
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_fixed();
      prio_mode = 1'b0;
      breq_ = 4'b0000;
      step();
      cmp++; if (bgrt_ !== 4'b1110 || owner !== 2'd0) begin err++; $display("FAIL fixed_first got %b owner %0d exp 1110/0", bgrt_, owner); end
      for (int i = 0; i < 15; i++) begin
         step();
         cmp++; if (bgrt_ !== 4'b1110) begin err++; $display("FAIL fixed_hold%0d got %b exp 1110", i, bgrt_); end
      end
      step();
      cmp++; if (bgrt_ !== 4'b1111) begin err++; $display("FAIL fixed_preempt got %b exp 1111", bgrt_); end
      step();
      cmp++; if (bgrt_ !== 4'b1111) begin err++; $display("FAIL fixed_gap got %b exp 1111", bgrt_); end
      step();
      cmp++; if (bgrt_ !== 4'b1110 || owner !== 2'd0) begin err++; $display("FAIL fixed_regrant got %b owner %0d exp 1110/0", bgrt_, owner); end
      idle_wait();
   endtask

   task automatic test_rr();
      logic [1:0] seq [5];
      logic [3:0] exp;
      seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      reset = 1'b1;
      step();
      reset = 1'b0;
      prio_mode = 1'b1;
      breq_ = 4'b0000;
      for (int k = 0; k < 5; k++) begin
         exp = 4'b1111;
         exp[seq[k]] = 1'b0;
         step();
         cmp++; if (bgrt_ !== exp || owner !== seq[k]) begin err++; $display("FAIL rr_grant%0d got %b owner %0d exp %b/%0d", k, bgrt_, owner, exp, seq[k]); end
         step(); step();
         cmp++; if (bgrt_ !== exp) begin err++; $display("FAIL rr_hold%0d got %b exp %b", k, bgrt_, exp); end
         breq_[seq[k]] = 1'b1;
         step();
         cmp++; if (bgrt_ !== 4'b1111) begin err++; $display("FAIL rr_handoff%0d got %b exp 1111", k, bgrt_); end
         breq_[seq[k]] = 1'b0;
         step();
         cmp++; if (bgrt_ !== 4'b1111) begin err++; $display("FAIL rr_idle%0d got %b exp 1111", k, bgrt_); end
      end
      idle_wait();
      prio_mode = 1'b0;
   endtask

   task automatic test_preempt();
      breq_ = 4'b1011;
      step();
      cmp++; if (bgrt_ !== 4'b1011 || owner !== 2'd2) begin err++; $display("FAIL pre_grant got %b owner %0d exp 1011/2", bgrt_, owner); end
      for (int i = 2; i <= 16; i++) begin
         if (i == 5) breq_ = 4'b1010;
         step();
      end
      cmp++; if (bgrt_ !== 4'b1011) begin err++; $display("FAIL pre_16th got %b exp 1011", bgrt_); end
      step();
      cmp++; if (bgrt_ !== 4'b1111) begin err++; $display("FAIL pre_drop got %b exp 1111", bgrt_); end
      step();
      cmp++; if (bgrt_ !== 4'b1111) begin err++; $display("FAIL pre_gap got %b exp 1111", bgrt_); end
      step();
      cmp++; if (bgrt_ !== 4'b1110 || s_addr !== 16'hA0A0) begin err++; $display("FAIL pre_m0 got %b addr %h exp 1110/a0a0", bgrt_, s_addr); end
      idle_wait();
   endtask

   task automatic test_late_drop();
      breq_ = 4'b0101;
      step();
      cmp++; if (bgrt_ !== 4'b1101) begin err++; $display("FAIL late_grant got %b exp 1101", bgrt_); end
      breq_ = 4'b0111;
      step();
      cmp++; if (bgrt_ !== 4'b1111) begin err++; $display("FAIL late_handoff got %b exp 1111", bgrt_); end
      breq_ = 4'b1111;
      step(); step();
      cmp++; if (bgrt_ !== 4'b1111 || bus_busy !== 1'b0) begin err++; $display("FAIL late_idle got %b busy %b exp 1111/0", bgrt_, bus_busy); end
      cmp++; if (s_rw_ !== 1'b1 || s_addr !== 16'h0) begin err++; $display("FAIL late_mux got rw=%b a=%h exp 1/0", s_rw_, s_addr); end
   endtask

   initial begin
      reset     = 1'b1;
      breq_     = 4'b1111;
      prio_mode = 1'b0;
      m_addr    = {16'hA3A3, 16'hA2A2, 16'hA1A1, 16'hA0A0};
      m_wdata   = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
      m_rw_     = 4'b1101;
      s_rdata   = 32'hDEAD_BEEF;
      step(); step();
      test_reset_state();
      reset = 1'b0;
      step();
      test_single();
      test_reset();
      test_fixed();
      test_rr();
      test_preempt();
      test_late_drop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
      $finish;
   end

endmodule
